// File: rtl/hsv_core_alu_shift_add.sv
// rtl/hsv_core_alu_shift_add.sv - ALU back end: funnel shift, 33-bit add, result select, writeback stall
//
// Purpose: two-stage pipeline behind the ALU bitwise-setup stage. Stage A
// performs the funnel shift and the 33-bit addition. Stage B selects the
// architectural result and presents it to writeback. While writeback
// back-pressures, stall_o freezes both stages and the setup stage.
//
// Ports:
//   clk_core       core clock
//   rst_core_n     asynchronous active-low reset (clears the valid bits only)
//   flush_req      kills every in-flight op at the next edge
//   valid_i        setup-stage output is valid
//   in_alu_data    op metadata, including out_select
//   in_shift_lo    low half of the 64-bit funnel
//   in_shift_hi    high half of the 64-bit funnel
//   in_shift_count right-shift amount applied to the funnel
//   in_adder_a     33-bit adder operand A
//   in_adder_b     33-bit adder operand B (already negated/flipped by setup)
//   stall_o        freeze request: result valid but writeback not ready
//   ready_i        writeback accepts this cycle
//   valid_o        result valid
//   out_alu_data   pass-through of the op metadata
//   out_result     final ALU result

package hsv_core_pkg;
  typedef logic [31:0] word;
  typedef logic [4:0]  shift;
  typedef logic [32:0] adder_in;

  typedef enum logic [1:0] {
    ALU_OUT_SHIFT = 2'd0,
    ALU_OUT_ADD   = 2'd1,
    ALU_OUT_SLT   = 2'd2
  } alu_out_select_t;

  typedef struct packed {
    alu_out_select_t out_select;
    logic [7:0]      tag;
  } alu_data_t;
endpackage

module hsv_core_alu_shift_add
  import hsv_core_pkg::*;
(
  input  logic      clk_core,
  input  logic      rst_core_n,
  input  logic      flush_req,
  input  logic      valid_i,
  input  alu_data_t in_alu_data,
  input  word       in_shift_lo,
  input  word       in_shift_hi,
  input  shift      in_shift_count,
  input  adder_in   in_adder_a,
  input  adder_in   in_adder_b,
  output logic      stall_o,
  input  logic      ready_i,
  output logic      valid_o,
  output alu_data_t out_alu_data,
  output word       out_result
);

  logic      a_valid;
  alu_data_t a_data;
  word       a_shift;
  adder_in   a_sum;

  word       shift_d;
  word       result_d;

  // Depends only on the output stage and writeback, never on valid_i, so the
  // setup stage can use it without a combinational loop through this block.
  assign stall_o = valid_o & ~ready_i;

  // Only the low word of the 64-bit logical shift is architecturally visible.
  assign shift_d = word'({in_shift_hi, in_shift_lo} >> in_shift_count);

  // Bit 32 of the 33-bit sum is the less-than flag; setup has already encoded
  // signed vs unsigned compare into the operand sign bits.
  always_comb begin
    result_d = 'x;
    case (a_data.out_select)
      ALU_OUT_SHIFT: result_d = a_shift;
      ALU_OUT_ADD:   result_d = a_sum[31:0];
      ALU_OUT_SLT:   result_d = {31'b0, a_sum[32]};
      default:       result_d = 'x;
    endcase
  end

  // Valid bits: flush wins over stall and over a new op.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      a_valid <= 1'b0;
      valid_o <= 1'b0;
    end else if (flush_req) begin
      a_valid <= 1'b0;
      valid_o <= 1'b0;
    end else if (!stall_o) begin
      a_valid <= valid_i;
      valid_o <= a_valid;
    end
  end

  // Data registers carry no reset; their contents only matter under a valid bit.
  always_ff @(posedge clk_core) begin
    if (!stall_o) begin
      a_data       <= in_alu_data;
      a_shift      <= shift_d;
      a_sum        <= in_adder_a + in_adder_b;
      out_alu_data <= a_data;
      out_result   <= result_d;
    end
  end

endmodule

// File: tb/tb_hsv_core_alu_shift_add.sv
// tb/tb_hsv_core_alu_shift_add.sv - bench for hsv_core_alu_shift_add
module tb_hsv_core_alu_shift_add;
  import hsv_core_pkg::*;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL  = 2;
  localparam int OP_SRL  = 3;
  localparam int OP_SRA  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_SLTU = 7;

  typedef struct packed {
    alu_data_t data;
    word       res;
  } exp_t;

  logic      clk_core = 1'b0;
  logic      rst_core_n = 1'b1;
  logic      flush_req = 1'b0;
  logic      valid_i = 1'b0;
  alu_data_t in_alu_data = '0;
  word       in_shift_lo = '0;
  word       in_shift_hi = '0;
  shift      in_shift_count = '0;
  adder_in   in_adder_a = '0;
  adder_in   in_adder_b = '0;
  logic      stall_o;
  logic      ready_i = 1'b1;
  logic      valid_o;
  alu_data_t out_alu_data;
  word       out_result;

  int   checks = 0;
  int   errors = 0;
  exp_t cur_exp = '0;
  exp_t sb[$];
  logic [7:0] tag_ctr = 8'h40;

  hsv_core_alu_shift_add dut (
    .clk_core       (clk_core),
    .rst_core_n     (rst_core_n),
    .flush_req      (flush_req),
    .valid_i        (valid_i),
    .in_alu_data    (in_alu_data),
    .in_shift_lo    (in_shift_lo),
    .in_shift_hi    (in_shift_hi),
    .in_shift_count (in_shift_count),
    .in_adder_a     (in_adder_a),
    .in_adder_b     (in_adder_b),
    .stall_o        (stall_o),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .out_alu_data   (out_alu_data),
    .out_result     (out_result)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural meaning of each op, independent of the setup encoding.
  function automatic word arch_result(input int op, input word rs1, input word rs2);
    logic [4:0] s;
    s = rs2[4:0];
    case (op)
      OP_ADD:  return rs1 + rs2;
      OP_SUB:  return rs1 - rs2;
      OP_SLL:  return rs1 << s;
      OP_SRL:  return rs1 >> s;
      OP_SRA:  return word'($signed(rs1) >>> s);
      OP_AND:  return rs1 & rs2;
      OP_SLT:  return ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
      OP_SLTU: return (rs1 < rs2) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // Plays the role of the setup stage: encodes an op onto the DUT inputs.
  task automatic present(input int op, input word rs1, input word rs2, input logic [7:0] tag);
    alu_out_select_t sel;
    word lo, hi;
    shift cnt;
    adder_in a, b;
    logic [4:0] s;
    s = rs2[4:0];
    sel = ALU_OUT_SHIFT; lo = '0; hi = '0; cnt = '0; a = '0; b = '0;
    case (op)
      OP_ADD:  begin sel = ALU_OUT_ADD; a = {1'b0, rs1}; b = {1'b0, rs2}; end
      OP_SUB:  begin sel = ALU_OUT_ADD; a = {1'b0, rs1}; b = -{1'b0, rs2}; end
      OP_SLL:  begin
                 if (s == 5'd0) lo = rs1;
                 else begin hi = rs1; cnt = 5'(32 - int'(s)); end
               end
      OP_SRL:  begin lo = rs1; cnt = s; end
      OP_SRA:  begin lo = rs1; hi = {32{rs1[31]}}; cnt = s; end
      OP_AND:  begin lo = rs1 & rs2; hi = 32'hDEADBEEF; end
      OP_SLT:  begin sel = ALU_OUT_SLT; a = {1'b0, rs1 ^ 32'h80000000}; b = -{1'b0, rs2 ^ 32'h80000000}; end
      OP_SLTU: begin sel = ALU_OUT_SLT; a = {1'b0, rs1}; b = -{1'b0, rs2}; end
      default: ;
    endcase
    in_alu_data    = '{out_select: sel, tag: tag};
    in_shift_lo    = lo;
    in_shift_hi    = hi;
    in_shift_count = cnt;
    in_adder_a     = a;
    in_adder_b     = b;
    cur_exp.data   = in_alu_data;
    cur_exp.res    = arch_result(op, rs1, rs2);
    valid_i        = 1'b1;
  endtask

  // Presents an op and holds it until it is consumed (returns #1 after that edge).
  task automatic send(input int op, input word rs1, input word rs2);
    logic acc;
    bit done;
    present(op, rs1, rs2, tag_ctr);
    tag_ctr = tag_ctr + 8'd1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      acc = !stall_o && !flush_req;
      step();
      if (acc) done = 1;
      else ready_i = 1'b1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Single op through an idle pipe: hand-computed result and two-cycle latency.
  task automatic run_one(input string name, input int op, input word rs1, input word rs2, input word lit);
    ready_i = 1'b1;
    send(op, rs1, rs2);
    valid_i = 1'b0;
    chk({name, "_early"}, 64'(valid_o), 64'd0);
    step();
    chk({name, "_valid"}, 64'(valid_o), 64'd1);
    chk(name, 64'(out_result), 64'(lit));
    step();
  endtask

  // Scoreboard: in-order queue of accepted ops, compared whenever a result is shown.
  always @(negedge clk_core) begin
    if (!rst_core_n) begin
      sb.delete();
    end else begin
      chk("stall_rule", 64'(stall_o), 64'(valid_o & ~ready_i));
      if (valid_o) begin
        if (sb.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          chk("sb_result", 64'(out_result), 64'(sb[0].res));
          chk("sb_data", 64'(out_alu_data), 64'(sb[0].data));
        end
      end
      if (flush_req) sb.delete();
      else begin
        if (valid_o && ready_i && sb.size() > 0) sb.delete(0);
        if (valid_i && !stall_o) sb.push_back(cur_exp);
      end
    end
  end

  int  t_op [0:10] = '{OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_AND, OP_SLT, OP_SLTU, OP_SLT, OP_SLL, OP_SLTU};
  word t_r1 [0:10] = '{32'd1, 32'd5, 32'h12345678, 32'h80000001, 32'h80000001, 32'h0000F0F0,
                       32'd5, 32'd5, 32'h80000000, 32'h000000A5, 32'd7};
  word t_r2 [0:10] = '{32'd2, 32'd9, 32'd8, 32'd31, 32'd31, 32'h0000FF00,
                       32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'd0, 32'd7};

  initial begin
    // Model pinned by hand-computed values.
    chk("model_add", 64'(arch_result(OP_ADD, 32'd5, 32'd3)), 64'h8);
    chk("model_sra", 64'(arch_result(OP_SRA, 32'h80000000, 32'd4)), 64'hF8000000);
    chk("model_slt", 64'(arch_result(OP_SLT, 32'hFFFFFFFF, 32'd1)), 64'd1);
    chk("model_sltu", 64'(arch_result(OP_SLTU, 32'hFFFFFFFF, 32'd1)), 64'd0);

    #1 rst_core_n = 1'b0;
    #1;
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_stall_o", 64'(stall_o), 64'd0);
    step(); step();
    rst_core_n = 1'b1;

    run_one("add", OP_ADD, 32'd5, 32'd3, 32'h00000008);
    run_one("sll4", OP_SLL, 32'h0000000F, 32'd4, 32'h000000F0);
    run_one("sra4", OP_SRA, 32'h80000000, 32'd4, 32'hF8000000);
    run_one("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
    run_one("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);

    // Back-to-back A, B, C with writeback stalled for three cycles.
    ready_i = 1'b1;
    present(OP_ADD, 32'd100, 32'd1, 8'hA1); step();
    present(OP_SUB, 32'd100, 32'd1, 8'hB2); step();
    chk("stall_a_out", 64'(out_alu_data.tag), 64'hA1);
    present(OP_SLL, 32'd1, 32'd31, 8'hC3);
    ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_high", 64'(stall_o), 64'd1);
      chk("stall_hold_a", 64'(out_alu_data.tag), 64'hA1);
      chk("stall_hold_res", 64'(out_result), 64'd101);
      step();
    end
    ready_i = 1'b1;
    #1;
    chk("stall_low", 64'(stall_o), 64'd0);
    step();
    valid_i = 1'b0;
    chk("order_b", 64'(out_alu_data.tag), 64'hB2);
    chk("order_b_res", 64'(out_result), 64'd99);
    step();
    chk("order_c", 64'(out_alu_data.tag), 64'hC3);
    chk("order_c_res", 64'(out_result), 64'h80000000);
    step();
    chk("order_drained", 64'(valid_o), 64'd0);

    // Flush with both stages full and writeback stalled.
    present(OP_ADD, 32'd1, 32'd1, 8'hD4); step();
    present(OP_ADD, 32'd2, 32'd2, 8'hE5); step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("pre_flush_stall", 64'(stall_o), 64'd1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("flush_valid_o", 64'(valid_o), 64'd0);
    chk("flush_stall_o", 64'(stall_o), 64'd0);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_result", 64'(valid_o), 64'd0);
    end

    // Flush arriving together with a new op drops that op.
    present(OP_ADD, 32'd9, 32'd9, 8'hF6);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    valid_i = 1'b0;
    step();
    chk("flush_drop_1", 64'(valid_o), 64'd0);
    step();
    chk("flush_drop_2", 64'(valid_o), 64'd0);

    // Asynchronous reset between edges with both stages full.
    present(OP_ADD, 32'd3, 32'd3, 8'h71); step();
    present(OP_ADD, 32'd4, 32'd4, 8'h72); step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    #2;
    chk("pre_reset_stall", 64'(stall_o), 64'd1);
    rst_core_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(valid_o), 64'd0);
    chk("async_reset_stall", 64'(stall_o), 64'd0);
    step(); step();
    rst_core_n = 1'b1;
    run_one("post_reset_add", OP_ADD, 32'hFFFFFFFF, 32'd2, 32'h00000001);

    // Directed stream with intermittent back-pressure, checked by the scoreboard.
    for (int i = 0; i < 11; i++) begin
      ready_i = (i % 3 != 2);
      send(t_op[i], t_r1[i], t_r2[i]);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) step();
    chk("stream_drained", 64'(sb.size()), 64'd0);
    chk("stream_idle", 64'(valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
